servo_pwm_decoder: RTL and testbench

- Receive side of the servo PWM link: measures high time and period of a 50 MHz-sampled servo pulse train (nominal 20 ms frame, 1–2 ms pulse).
- Converts each accepted pulse into the 2-bit cmd code used by the PWM generator, so a board can read back another board's servo command, or loop back its own for self-check.
- Reports a timeout when the frame stops arriving.

---
 rtl/servo_pwm_decoder_if.sv | 24 ++
 rtl/servo_pwm_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_decoder_if.sv
// Servo PWM decoder bus: the raw PWM pin toward the decoder and the
// measured width/period, decoded command and status back from it.
// The decoder sits on the master side; the consumer of the measurements
// (and the source of the pin) sits on the slave side.
interface servo_pwm_decoder_if;
  logic        pwm_in;
  logic [20:0] width;
  logic [20:0] period;
  logic        width_valid;
  logic        period_valid;
  logic [1:0]  cmd;
  logic        err;
  logic        lost;

  modport master (
    input  pwm_in,
    output width, period, width_valid, period_valid, cmd, err, lost
  );

  modport slave (
    output pwm_in,
    input  width, period, width_valid, period_valid, cmd, err, lost
  );
endinterface

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures high time and rise-to-rise period of a servo
// pulse train, decodes accepted pulses into the 2-bit servo command and
// flags out-of-range pulses and loss of the frame.
// Optional macro GLITCH_FILTER_EN: when defined, the synchronized input must
// hold a new level for FILT_LEN cycles before it is treated as an edge.
module servo_pwm_decoder #(
  parameter int MIN_W      = 25000,
  parameter int MAX_W      = 125000,
  parameter int CMD_LO_MAX = 62500,
  parameter int CMD_HI_MIN = 87500,
  parameter int TIMEOUT    = 1200000,
  parameter int FILT_LEN   = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  servo_pwm_decoder_if.master bus
);

  localparam int CW = 21;
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] MIN_W_C   = CW'(MIN_W);
  localparam logic [CW-1:0] MAX_W_C   = CW'(MAX_W);
  localparam logic [CW-1:0] LO_MAX_C  = CW'(CMD_LO_MAX);
  localparam logic [CW-1:0] HI_MIN_C  = CW'(CMD_HI_MIN);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  // Startup settling time; long enough for the synchronizer and filter to
  // show the true pin level before IDLE may accept a rise.
  localparam int WARM = FILT_LEN + 4;
  localparam int WW   = $clog2(WARM + 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LOST} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, levelDly_q, level;
  logic          rise, fall, timedOut, inRange;
  logic [WW-1:0] warmCnt_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q, cnt_d, perCnt_q, perCnt_d;
  logic [CW-1:0] width_q, width_d, period_q, period_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          widthValid_q, widthValid_d, periodValid_q, periodValid_d;
  logic          err_q, err_d, lost_q, lost_d;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  // Two-flop synchronizer plus a delayed copy of the level for edge detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      levelDly_q <= 1'b0;
    end else begin
      sync1_q    <= bus.pwm_in;
      sync2_q    <= sync1_q;
      levelDly_q <= level;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN) + 1;
  logic          filt_q;
  logic [FW-1:0] filtCnt_q;

  // Accept a new level only after it has been stable for FILT_LEN cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q    <= 1'b0;
      filtCnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      filtCnt_q <= '0;
    end else if (filtCnt_q == FW'(FILT_LEN - 1)) begin
      filt_q    <= sync2_q;
      filtCnt_q <= '0;
    end else begin
      filtCnt_q <= filtCnt_q + FW'(1);
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign rise     = level & ~levelDly_q;
  assign fall     = ~level & levelDly_q;
  assign timedOut = (cnt_q >= TIMEOUT_C);
  assign inRange  = (cnt_q >= MIN_W_C) && (cnt_q <= MAX_W_C);

  // Arm IDLE once the settled pin has been seen low, so a pulse already in
  // progress when reset releases is never measured
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warmCnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      if (warmCnt_q != WW'(WARM)) warmCnt_q <= warmCnt_q + WW'(1);
      armed_q <= armed_q | ((warmCnt_q == WW'(WARM)) & ~level);
    end
  end

  // Phase counter (high time, low time, idle time) and rise-to-rise counter
  always_comb begin
    cnt_d    = satInc(cnt_q);
    perCnt_d = rise ? CW'(1) : satInc(perCnt_q);
    case (state_q)
      IDLE:    if (rise || fall) cnt_d = (rise && armed_q) ? CW'(1) : '0;
      HIGH:    if (fall) cnt_d = CW'(1);
      LOW:     if (rise) cnt_d = CW'(1);
      LOST:    cnt_d = rise ? CW'(1) : '0;
      default: cnt_d = '0;
    endcase
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      perCnt_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      perCnt_q <= perCnt_d;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an edge always wins over a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise && armed_q)             state_d = HIGH;
        else if (!rise && !fall && timedOut) state_d = LOST;
      end
      HIGH: begin
        if (fall)          state_d = LOW;
        else if (timedOut) state_d = LOST;
      end
      LOW: begin
        if (rise)          state_d = HIGH;
        else if (timedOut) state_d = LOST;
      end
      LOST:    if (rise) state_d = HIGH;
      default: state_d = IDLE;
    endcase
  end

  // Output next values: measurements, strobes, command decode and loss flag
  always_comb begin
    width_d       = width_q;
    period_d      = period_q;
    cmd_d         = cmd_q;
    widthValid_d  = 1'b0;
    periodValid_d = 1'b0;
    err_d         = 1'b0;
    lost_d        = (state_d == LOST);
    case (state_q)
      HIGH: begin
        if (fall) begin
          if (inRange) begin
            width_d      = cnt_q;
            widthValid_d = 1'b1;
            if (cnt_q <= LO_MAX_C)      cmd_d = 2'b01;
            else if (cnt_q >= HI_MIN_C) cmd_d = 2'b10;
            else                        cmd_d = 2'b00;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOW: begin
        if (rise) begin
          period_d      = perCnt_q;
          periodValid_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == LOST && state_q != LOST) cmd_d = 2'b00;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      width_q       <= '0;
      period_q      <= '0;
      cmd_q         <= 2'b00;
      widthValid_q  <= 1'b0;
      periodValid_q <= 1'b0;
      err_q         <= 1'b0;
      lost_q        <= 1'b0;
    end else begin
      width_q       <= width_d;
      period_q      <= period_d;
      cmd_q         <= cmd_d;
      widthValid_q  <= widthValid_d;
      periodValid_q <= periodValid_d;
      err_q         <= err_d;
      lost_q        <= lost_d;
    end
  end

  assign bus.width        = width_q;
  assign bus.period       = period_q;
  assign bus.cmd          = cmd_q;
  assign bus.width_valid  = widthValid_q;
  assign bus.period_valid = periodValid_q;
  assign bus.err          = err_q;
  assign bus.lost         = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Testbench for servo_pwm_decoder with timing parameters scaled down by 500
// (1 ms = 100 cycles) so whole frames fit in a short simulation.
module tb_servo_pwm_decoder;

  localparam int MIN_W      = 50;
  localparam int MAX_W      = 250;
  localparam int CMD_LO_MAX = 125;
  localparam int CMD_HI_MIN = 175;
  localparam int TIMEOUT    = 2400;
  localparam int FILT_LEN   = 8;

  logic clk;
  logic rst_n;

  servo_pwm_decoder_if bus ();

  servo_pwm_decoder #(
    .MIN_W(MIN_W), .MAX_W(MAX_W), .CMD_LO_MAX(CMD_LO_MAX),
    .CMD_HI_MIN(CMD_HI_MIN), .TIMEOUT(TIMEOUT), .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event log filled from the DUT strobes, sampled on the falling edge
  int gotWidth [512];
  int gotCmd [512];
  int gotPeriod [512];
  int gotWidthN = 0;
  int gotPeriodN = 0;
  int gotErrN = 0;

  // Record every strobe the DUT produces
  always @(negedge clk) begin
    if (bus.width_valid) begin
      if (gotWidthN < 512) begin
        gotWidth[gotWidthN] <= int'(bus.width);
        gotCmd[gotWidthN]   <= int'(bus.cmd);
      end
      gotWidthN <= gotWidthN + 1;
    end
    if (bus.period_valid) begin
      if (gotPeriodN < 512) gotPeriod[gotPeriodN] <= int'(bus.period);
      gotPeriodN <= gotPeriodN + 1;
    end
    if (bus.err) gotErrN <= gotErrN + 1;
  end

  // Reference model: expected strobes and output levels from pulse durations
  int expWidthQ [$];
  int expCmdQ [$];
  int expPeriodQ [$];
  int expErrN = 0;
  int rdW = 0;
  int rdP = 0;
  int expWidth = 0;
  int expCmd = 0;
  int expPeriod = 0;
  int expLost = 0;
  bit tracking = 1'b0;
  int prevHigh = 0;
  int prevLow = 0;

  int dirHigh [13] = '{100, 200, 150, 20, 300, MIN_W, MAX_W, MIN_W - 1,
                       MAX_W + 1, CMD_LO_MAX, CMD_LO_MAX + 1,
                       CMD_HI_MIN - 1, CMD_HI_MIN};

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int decodeCmd(input int w);
    if (w <= CMD_LO_MAX) return 1;
    if (w >= CMD_HI_MIN) return 2;
    return 0;
  endfunction

  task automatic modelRise();
    if (tracking) begin
      expPeriod = prevHigh + prevLow;
      expPeriodQ.push_back(expPeriod);
    end
    tracking = 1'b1;
    expLost  = 0;
  endtask

  task automatic modelFall(input int high);
    if (high >= MIN_W && high <= MAX_W) begin
      expWidth = high;
      expCmd   = decodeCmd(high);
      expWidthQ.push_back(expWidth);
      expCmdQ.push_back(expCmd);
    end else begin
      expErrN++;
    end
  endtask

  task automatic modelReset();
    tracking  = 1'b0;
    expWidth  = 0;
    expCmd    = 0;
    expPeriod = 0;
    expLost   = 0;
  endtask

  task automatic drivePin(input logic v, input int n);
    bus.pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int high, input int low);
    drivePin(1'b1, high);
    drivePin(1'b0, low);
    modelRise();
    modelFall(high);
    prevHigh = high;
    prevLow  = low;
  endtask

  task automatic checkEvents();
    checkOutput("widthCount", gotWidthN - rdW, expWidthQ.size());
    while (expWidthQ.size() > 0 && rdW < gotWidthN) begin
      checkOutput("widthEvent", gotWidth[rdW], expWidthQ.pop_front());
      checkOutput("cmdEvent", gotCmd[rdW], expCmdQ.pop_front());
      rdW++;
    end
    expWidthQ.delete();
    expCmdQ.delete();
    rdW = gotWidthN;
    checkOutput("periodCount", gotPeriodN - rdP, expPeriodQ.size());
    while (expPeriodQ.size() > 0 && rdP < gotPeriodN) begin
      checkOutput("periodEvent", gotPeriod[rdP], expPeriodQ.pop_front());
      rdP++;
    end
    expPeriodQ.delete();
    rdP = gotPeriodN;
    checkOutput("errCount", gotErrN, expErrN);
    expErrN = gotErrN;
    checkOutput("widthLevel", int'(bus.width), expWidth);
    checkOutput("cmdLevel", int'(bus.cmd), expCmd);
    checkOutput("periodLevel", int'(bus.period), expPeriod);
    checkOutput("lostLevel", int'(bus.lost), expLost);
  endtask

  task automatic checkResetState();
    checkOutput("rstWidth", int'(bus.width), 0);
    checkOutput("rstPeriod", int'(bus.period), 0);
    checkOutput("rstCmd", int'(bus.cmd), 0);
    checkOutput("rstWidthValid", int'(bus.width_valid), 0);
    checkOutput("rstPeriodValid", int'(bus.period_valid), 0);
    checkOutput("rstErr", int'(bus.err), 0);
    checkOutput("rstLost", int'(bus.lost), 0);
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    rst_n = 1'b1;
    drivePin(1'b0, 30);

    // Directed widths: nominal frames, short/long errors, decode boundaries
    for (int i = 0; i < 13; i++) begin
      applyStimulus(dirHigh[i], (i < 3) ? 2000 - dirHigh[i] : 1000 - dirHigh[i]);
      checkEvents();
    end

    // Short low glitch inside a 1 ms pulse
    drivePin(1'b1, 30);
    drivePin(1'b0, 3);
    drivePin(1'b1, 67);
    drivePin(1'b0, 900);
`ifdef GLITCH_FILTER_EN
    modelRise();
    modelFall(100);
    prevHigh = 100;
    prevLow  = 900;
`else
    modelRise();
    modelFall(30);
    prevHigh = 30;
    prevLow  = 3;
    modelRise();
    modelFall(67);
    prevHigh = 67;
    prevLow  = 900;
`endif
    checkEvents();

    // Random frames
    for (int i = 0; i < 20; i++) begin
      int h;
      int l;
      h = int'($urandom_range(300, 20));
      l = int'($urandom_range(1500, 30));
      applyStimulus(h, l);
      checkEvents();
    end

    // Loss of frame: pin held low after a valid pulse
    drivePin(1'b1, 100);
    bus.pwm_in = 1'b0;
    modelRise();
    modelFall(100);
    repeat (TIMEOUT - 20) @(posedge clk);
    #1;
    checkEvents();
    repeat (40) @(posedge clk);
    #1;
    tracking = 1'b0;
    expCmd   = 0;
    expLost  = 1;
    checkEvents();
    drivePin(1'b0, 500);
    applyStimulus(150, 1000);
    checkEvents();
    applyStimulus(100, 1000);
    checkEvents();

    // Reset 40 cycles into a pulse; the remainder must be ignored
    drivePin(1'b1, 40);
    modelRise();
    rst_n = 1'b0;
    drivePin(1'b1, 3);
    checkResetState();
    modelReset();
    rst_n = 1'b1;
    drivePin(1'b1, 60);
    drivePin(1'b0, 500);
    checkEvents();
    applyStimulus(100, 1000);
    checkEvents();
    applyStimulus(200, 1000);
    checkEvents();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
